// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and one-cycle access sequencer for the
// single-ported data memory. Port 0 is the core load/store unit, port 1 the
// program/data loader.
// Build option: DMEM_ARB_RR_EN selects round-robin tie-break; without it,
// port 0 always wins a tie and no last-grant state exists.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_byte,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_rerr,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_byte,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_rerr,
  output logic        mem_read,
  output logic        mem_write,
  output logic        load_byte,
  output logic        store_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_cmd_we;
  logic        r_cmd_byte;
  logic        r_cmd_err;
  logic        r_cmd_port;
  logic [31:0] r_cmd_addr;
  logic [31:0] r_cmd_wdata;

  logic        r_p0_rvalid;
  logic [31:0] r_p0_rdata;
  logic        r_p0_rerr;
  logic        r_p1_rvalid;
  logic [31:0] r_p1_rdata;
  logic        r_p1_rerr;

  logic        w_win;
  logic        w_capture;
  logic        w_sel_we;
  logic        w_sel_byte;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [31:0] w_done_rdata;

`ifdef DMEM_ARB_RR_EN
  logic        r_last_gnt;
`endif

  // Misaligned word access or address beyond the memory is an error.
  function automatic logic f_access_err(input logic i_byte, input logic [31:0] i_addr);
    logic w_misaligned;
    logic w_range;
    w_misaligned = !i_byte && (i_addr[1:0] != 2'b00);
    w_range      = (i_addr >= 32'(MEM_BYTES));
    return w_misaligned || w_range;
  endfunction

  // Winner selection: a lone requester wins; ties use the configured policy.
  always_comb begin
    w_win = 1'b0;
    if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
      w_win = ~r_last_gnt;
`else
      w_win = 1'b0;
`endif
    end else if (p1_req) begin
      w_win = 1'b1;
    end else begin
      w_win = 1'b0;
    end
  end

  // A grant is only given from IDLE and never while reset is held.
  assign w_capture   = (r_state == ST_IDLE) && (p0_req || p1_req) && !rst;
  assign p0_gnt      = w_capture && !w_win;
  assign p1_gnt      = w_capture && w_win;
  assign w_sel_we    = w_win ? p1_we    : p0_we;
  assign w_sel_byte  = w_win ? p1_byte  : p0_byte;
  assign w_sel_addr  = w_win ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_win ? p1_wdata : p0_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: IDLE -> ACCESS on a grant, ACCESS always returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_next_state = ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Memory controls: only an error-free command touches the memory.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    load_byte  = 1'b0;
    store_byte = 1'b0;
    mem_addr   = 32'h0000_0000;
    mem_wdata  = 32'h0000_0000;
    case (r_state)
      ST_ACCESS: begin
        if (!r_cmd_err) begin
          mem_addr  = r_cmd_addr;
          mem_wdata = r_cmd_wdata;
          if (r_cmd_we) begin
            mem_write  = !rst;
            store_byte = r_cmd_byte;
          end else begin
            mem_read  = 1'b1;
            load_byte = r_cmd_byte;
          end
        end else begin
          mem_read = 1'b0;
        end
      end
      ST_IDLE: mem_read = 1'b0;
      default: mem_read = 1'b0;
    endcase
  end

  // Command registers: capture the winning payload and its error status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_we    <= 1'b0;
      r_cmd_byte  <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_cmd_port  <= 1'b0;
      r_cmd_addr  <= 32'h0000_0000;
      r_cmd_wdata <= 32'h0000_0000;
    end else if (w_capture) begin
      r_cmd_we    <= w_sel_we;
      r_cmd_byte  <= w_sel_byte;
      r_cmd_err   <= f_access_err(w_sel_byte, w_sel_addr);
      r_cmd_port  <= w_win;
      r_cmd_addr  <= w_sel_addr;
      r_cmd_wdata <= w_sel_wdata;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember the last granted port so the other one wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
    end else if (w_capture) begin
      r_last_gnt <= w_win;
    end
  end
`endif

  assign w_done_rdata = (!r_cmd_err && !r_cmd_we) ? mem_rdata : 32'h0000_0000;

  // Completion: pulse rvalid for the winner and hold its data/error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_rvalid <= 1'b0;
      r_p0_rdata  <= 32'h0000_0000;
      r_p0_rerr   <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p1_rdata  <= 32'h0000_0000;
      r_p1_rerr   <= 1'b0;
    end else begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      if (r_state == ST_ACCESS) begin
        if (r_cmd_port == 1'b0) begin
          r_p0_rvalid <= 1'b1;
          r_p0_rdata  <= w_done_rdata;
          r_p0_rerr   <= r_cmd_err;
        end else begin
          r_p1_rvalid <= 1'b1;
          r_p1_rdata  <= w_done_rdata;
          r_p1_rerr   <= r_cmd_err;
        end
      end
    end
  end

  assign p0_rvalid = r_p0_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p0_rerr   = r_p0_rerr;
  assign p1_rvalid = r_p1_rvalid;
  assign p1_rdata  = r_p1_rdata;
  assign p1_rerr   = r_p1_rerr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model that
// sign-extends byte loads like data_memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p0_byte;
  logic [31:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_rvalid, p0_rerr;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we, p1_byte;
  logic [31:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid, p1_rerr;
  logic [31:0] p1_rdata;
  logic        mem_read, mem_write, load_byte, store_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem [0:4095];
  logic        tb_clr;
  logic [11:0] ma;
  int          n_checks;
  int          n_errors;

  dmem_arbiter #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_byte(p0_byte), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_rerr(p0_rerr),
    .p1_req(p1_req), .p1_we(p1_we), .p1_byte(p1_byte), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_rerr(p1_rerr),
    .mem_read(mem_read), .mem_write(mem_write), .load_byte(load_byte),
    .store_byte(store_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ma = mem_addr[11:0];

  // Memory model write port (little-endian), with a clear for bench start.
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      if (store_byte) begin
        mem[ma] <= mem_wdata[7:0];
      end else begin
        mem[ma]         <= mem_wdata[7:0];
        mem[ma + 12'd1] <= mem_wdata[15:8];
        mem[ma + 12'd2] <= mem_wdata[23:16];
        mem[ma + 12'd3] <= mem_wdata[31:24];
      end
    end
  end

  // Memory model combinational read port.
  always_comb begin
    mem_rdata = 32'h0000_0000;
    if (mem_read) begin
      if (load_byte) mem_rdata = {{24{mem[ma][7]}}, mem[ma]};
      else           mem_rdata = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
    end else begin
      mem_rdata = 32'h0000_0000;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one request, check its grant, and advance into the ACCESS cycle.
  task automatic issue(input logic port, input logic we, input logic bt,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port == 1'b0) begin
      p0_req = 1'b1; p0_we = we; p0_byte = bt; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_byte = bt; p1_addr = addr; p1_wdata = wd;
    end
    #1;
    chk("gnt_p0", {31'd0, p0_gnt}, {31'd0, ~port});
    chk("gnt_p1", {31'd0, p1_gnt}, {31'd0, port});
    tick();
    p0_req = 1'b0;
    p1_req = 1'b0;
    #1;
  endtask

  initial begin
    logic e0, e1;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; tb_clr = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_byte = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_byte = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rst_gnt",    {30'd0, p0_gnt, p1_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    chk("rst_mem",    {28'd0, mem_read, mem_write, load_byte, store_byte}, 32'd0);
    chk("rst_rdata0", p0_rdata, 32'h0);
    rst = 1'b0; tb_clr = 1'b0;

    // Port 0 word store 0xDEADBEEF to 0x100
    issue(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    chk("st_mem_write", {31'd0, mem_write}, 32'd1);
    chk("st_mem_read",  {31'd0, mem_read}, 32'd0);
    chk("st_addr",      mem_addr, 32'h100);
    chk("st_wdata",     mem_wdata, 32'hDEADBEEF);
    chk("st_no_gnt",    {31'd0, p0_gnt}, 32'd0);
    tick();
    chk("st_rvalid",    {31'd0, p0_rvalid}, 32'd1);
    chk("st_rerr",      {31'd0, p0_rerr}, 32'd0);
    chk("st_rdata",     p0_rdata, 32'h0);
    chk("st_idle_wr",   {31'd0, mem_write}, 32'd0);

    // Port 0 word load from 0x100
    issue(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    chk("ld_mem_read",  {31'd0, mem_read}, 32'd1);
    chk("ld_load_byte", {31'd0, load_byte}, 32'd0);
    tick();
    chk("ld_rvalid",    {31'd0, p0_rvalid}, 32'd1);
    chk("ld_rdata",     p0_rdata, 32'hDEADBEEF);
    chk("ld_rerr",      {31'd0, p0_rerr}, 32'd0);
    tick();
    chk("ld_pulse_end", {31'd0, p0_rvalid}, 32'd0);

    // Port 1 byte load at 0x103
    issue(1'b1, 1'b0, 1'b1, 32'h103, 32'h0);
    chk("lb_mem_read",  {31'd0, mem_read}, 32'd1);
    chk("lb_load_byte", {31'd0, load_byte}, 32'd1);
    chk("lb_addr",      mem_addr, 32'h103);
    tick();
    chk("lb_rvalid1",   {31'd0, p1_rvalid}, 32'd1);
    chk("lb_rvalid0",   {31'd0, p0_rvalid}, 32'd0);
    chk("lb_rdata",     p1_rdata, 32'hFFFFFFDE);
    chk("lb_rerr",      {31'd0, p1_rerr}, 32'd0);
    chk("p0_hold",      p0_rdata, 32'hDEADBEEF);

    // Port 0 misaligned word load at 0x102
    issue(1'b0, 1'b0, 1'b0, 32'h102, 32'h0);
    chk("mis_mem_read", {31'd0, mem_read}, 32'd0);
    tick();
    chk("mis_rvalid",   {31'd0, p0_rvalid}, 32'd1);
    chk("mis_rerr",     {31'd0, p0_rerr}, 32'd1);
    chk("mis_rdata",    p0_rdata, 32'h0);

    // Port 1 out-of-range word store at 0x1000
    issue(1'b1, 1'b1, 1'b0, 32'h1000, 32'h12345678);
    chk("oor_mem_write", {31'd0, mem_write}, 32'd0);
    tick();
    chk("oor_rvalid",   {31'd0, p1_rvalid}, 32'd1);
    chk("oor_rerr",     {31'd0, p1_rerr}, 32'd1);
    chk("oor_rdata",    p1_rdata, 32'h0);
    chk("oor_mem0",     {mem[3], mem[2], mem[1], mem[0]}, 32'h0);
    chk("oor_mem100",   {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'hDEADBEEF);

    // Store 0x200, then a second store aborted by reset during ACCESS
    issue(1'b0, 1'b1, 1'b0, 32'h200, 32'h11223344);
    tick();
    issue(1'b0, 1'b1, 1'b0, 32'h200, 32'h55667788);
    rst = 1'b1;
    #1;
    chk("rstacc_write", {31'd0, mem_write}, 32'd0);
    tick();
    chk("rstacc_gnt",   {30'd0, p0_gnt, p1_gnt}, 32'd0);
    chk("rstacc_rvld",  {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    chk("rstacc_rerr",  {30'd0, p0_rerr, p1_rerr}, 32'd0);
    chk("rstacc_mem",   {28'd0, mem_read, mem_write, load_byte, store_byte}, 32'd0);
    chk("rstacc_maddr", mem_addr, 32'h0);
    chk("rstacc_rd0",   p0_rdata, 32'h0);
    chk("rstacc_rd1",   p1_rdata, 32'h0);
    rst = 1'b0;
    tick();
    chk("rstacc_norv",  {31'd0, p0_rvalid}, 32'd0);
    issue(1'b0, 1'b0, 1'b0, 32'h200, 32'h0);
    tick();
    chk("rstacc_load",  p0_rdata, 32'h11223344);

    // Continuous requests on both ports from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_byte = 1'b0; p0_addr = 32'h100;
    p1_req = 1'b1; p1_we = 1'b0; p1_byte = 1'b0; p1_addr = 32'h200;
    #1;
    for (int c = 0; c < 8; c++) begin
      if ((c % 2) == 1) begin
        e0 = 1'b0; e1 = 1'b0;
      end else begin
`ifdef DMEM_ARB_RR_EN
        e0 = ((c % 4) == 0);
        e1 = ((c % 4) == 2);
`else
        e0 = 1'b1;
        e1 = 1'b0;
`endif
      end
      chk($sformatf("tie_gnt0_c%0d", c), {31'd0, p0_gnt}, {31'd0, e0});
      chk($sformatf("tie_gnt1_c%0d", c), {31'd0, p1_gnt}, {31'd0, e1});
      if (c == 2) begin
        chk("tie_rvalid0", {31'd0, p0_rvalid}, 32'd1);
        chk("tie_rdata0",  p0_rdata, 32'hDEADBEEF);
      end
      tick();
      #1;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
